cpu_run_ctrl: RTL and testbench

- Sequencer between the 8-bit CPU core and its instruction memory.
- Owns the single-port instruction RAM and shares it between a byte-wide program loader and CPU instruction fetch.
- Gates CPU execution with a one-cycle clock enable per instruction, supporting run, single-step, halt-request, halt-instruction and a watchdog.
- Drives the running LED and the retired-instruction count shown on the seven-segment displays.

---
 rtl/cpu_run_ctrl_pkg.sv | 27 ++
 rtl/cpu_run_ctrl_imem_port_mux.sv | 19 +
 rtl/cpu_run_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller: FSM state, run mode,
// halt opcode default and the CPU opcode field encodings.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

  localparam logic [7:0] HALT_INSTR_DEF = 8'hFF;
  localparam int         MAX_INSTR_DEF  = 1000;
  localparam int         CNT_W_DEF      = 16;

  // Top two opcode bits of a CPU instruction
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JMP   = 2'b11;

endpackage

// File: rtl/cpu_run_ctrl_imem_port_mux.sv
// Single-port instruction RAM arbitration: an accepted loader write owns the
// port, otherwise the CPU program counter addresses it for fetch.
module imem_port_mux (
  input  logic       i_load_sel,
  input  logic [7:0] i_load_addr,
  input  logic [7:0] i_load_data,
  input  logic [7:0] i_cpu_pc,
  output logic [7:0] o_mem_addr,
  output logic       o_mem_we,
  output logic [7:0] o_mem_wdata
);

  always_comb begin
    o_mem_addr  = i_load_sel ? i_load_addr : i_cpu_pc;
    o_mem_we    = i_load_sel;
    o_mem_wdata = i_load_sel ? i_load_data : 8'h00;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller between the 8-bit CPU and its instruction RAM: fetch/execute
// sequencing with run, step, halt request, halt opcode and retired-count watchdog.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter logic [7:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int         MAX_INSTR  = MAX_INSTR_DEF,
  parameter int         CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [7:0]       load_addr,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  input  logic [7:0]       cpu_pc,
  output logic [7:0]       cpu_instr,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic             runningLED,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam bit               LP_WD_EN = (MAX_INSTR != 0);
  localparam logic [CNT_W-1:0] LP_WD_MAX = CNT_W'(MAX_INSTR);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode;
  logic             r_stop;
  logic             r_timeout;
  logic             r_cpu_rst;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_halt, w_exec_ok, w_idle_hlt, w_clear_acc;
  logic             w_go, w_wd_hit, w_stop_now, w_load_sel;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_is_halt   = (mem_rdata == HALT_INSTR);
  assign w_exec_ok   = (r_state == ST_EXEC) && !w_is_halt;
  assign w_idle_hlt  = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign w_clear_acc = clear && w_idle_hlt;
  assign w_go        = start || step;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_wd_hit    = LP_WD_EN && (w_cnt_inc == LP_WD_MAX);
  // A halt request or watchdog hit in the last EXEC cycle still stops this exit
  assign w_stop_now  = r_stop || halt_req || (w_exec_ok && w_wd_hit);
  assign w_load_sel  = load_valid && load_ready;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_is_halt)                              w_state_nxt = ST_HALT;
        else if (r_mode == MODE_RUN && !w_stop_now) w_state_nxt = ST_FETCH;
        else if (r_mode == MODE_STEP)               w_state_nxt = ST_IDLE;
        else                                        w_state_nxt = ST_HALT;
      end
      ST_HALT:  if (clear) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; reset masks anything that could disturb the CPU or RAM mid-abort
  always_comb begin
    cpu_en     = w_exec_ok && !reset;
    cpu_instr  = (r_state == ST_EXEC && !reset) ? mem_rdata : 8'h00;
    load_ready = w_idle_hlt && !reset;
    runningLED = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    halted     = (r_state == ST_HALT);
  end

  // Run mode, stop flag, counter, watchdog flag and CPU reset stretch
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_mode    <= MODE_RUN;
      r_stop    <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_cpu_rst <= w_clear_acc;
      if (r_state == ST_IDLE && w_go)
        r_mode <= start ? MODE_RUN : MODE_STEP;
      // EXEC always exits, so any pending stop is consumed there
      if (w_clear_acc || r_state == ST_EXEC) r_stop <= 1'b0;
      else if (r_state == ST_FETCH && halt_req) r_stop <= 1'b1;
      if (w_clear_acc)    r_cnt <= '0;
      else if (w_exec_ok) r_cnt <= w_cnt_inc;
      if (w_clear_acc)                r_timeout <= 1'b0;
      else if (w_exec_ok && w_wd_hit) r_timeout <= 1'b1;
    end
  end

  assign cpu_rst     = reset || r_cpu_rst;
  assign timeout     = r_timeout;
  assign instr_count = r_cnt;

  imem_port_mux u_mux (
    .i_load_sel  (w_load_sel),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_cpu_pc    (cpu_pc),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a behavioural RAM and a PC-only CPU model.
module tb_cpu_run_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, step = 1'b0, halt_req = 1'b0, clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_addr = 8'h00, load_data = 8'h00;
  logic        load_ready;
  logic [7:0]  cpu_pc;
  logic [7:0]  cpu_instr;
  logic        cpu_en, cpu_rst;
  logic [7:0]  mem_addr, mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        runningLED, halted, timeout;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] mem [256];
  int         en_q[$];
  logic [7:0] ins_q[$];

  cpu_run_ctrl #(.HALT_INSTR(8'hFF), .MAX_INSTR(5), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
    .clear(clear), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .cpu_pc(cpu_pc),
    .cpu_instr(cpu_instr), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .runningLED(runningLED), .halted(halted),
    .timeout(timeout), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (cpu_rst)     cpu_pc <= 8'h00;
    else if (cpu_en) cpu_pc <= cpu_pc + 8'h01;
  end

  always @(negedge CLK) begin
    if (cpu_en) begin
      en_q.push_back(cyc);
      ins_q.push_back(cpu_instr);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (cpu_en !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL rst_en_rdy got=%b%b exp=00", cpu_en, load_ready); end
    total++; if ({runningLED, halted, timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {runningLED, halted, timeout}); end
    total++; if (instr_count !== 16'd0 || cpu_instr !== 8'h00) begin bad++; $display("FAIL rst_cnt_instr got=%h/%h exp=0/0", instr_count, cpu_instr); end
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_stretch got=%b exp=1", cpu_rst); end
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL rst_release got=%b%b exp=01", cpu_rst, load_ready); end
    tick();
  endtask

  task automatic test_run_halt_instr();
    int s, n;
    bit seen;
    load(8'd0, 8'h44); load(8'd1, 8'h49); load(8'd2, 8'h19);
    load(8'd3, 8'h84); load(8'd4, 8'hFF);
    total++; if (mem[4] !== 8'hFF || mem[0] !== 8'h44) begin bad++; $display("FAIL load_write got=%h/%h exp=ff/44", mem[4], mem[0]); end
    n = en_q.size();
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge CLK); if (halted) seen = 1; end
    total++; if (!seen) begin bad++; $display("FAIL run_timeout got=0 exp=halted"); end
    total++; if (en_q.size() - n !== 4) begin bad++; $display("FAIL run_en_count got=%0d exp=4", en_q.size() - n); end
    if (en_q.size() - n >= 4) begin
      total++; if (en_q[n] - s !== 2) begin bad++; $display("FAIL run_first_latency got=%0d exp=2", en_q[n] - s); end
      total++; if (en_q[n+3] - en_q[n] !== 6) begin bad++; $display("FAIL run_spacing got=%0d exp=6", en_q[n+3] - en_q[n]); end
      total++; if (ins_q[n] !== 8'h44 || ins_q[n+3] !== 8'h84) begin bad++; $display("FAIL run_instr got=%h/%h exp=44/84", ins_q[n], ins_q[n+3]); end
    end
    total++; if (instr_count !== 16'd4 || timeout !== 1'b0) begin bad++; $display("FAIL run_cnt_to got=%0d/%b exp=4/0", instr_count, timeout); end
  endtask

  task automatic test_step();
    int n;
    do_clear();
    total++; if (halted !== 1'b0 || instr_count !== 16'd0) begin bad++; $display("FAIL step_clear got=%b/%0d exp=0/0", halted, instr_count); end
    for (int k = 0; k < 3; k++) begin
      n = en_q.size();
      step = 1'b1; tick(); step = 1'b0;
      repeat (5) tick();
      total++; if (en_q.size() - n !== 1) begin bad++; $display("FAIL step_en got=%0d exp=1", en_q.size() - n); end
      @(negedge CLK);
      total++; if (runningLED !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL step_idle got=%b%b exp=00", runningLED, halted); end
      tick();
    end
    total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL step_cnt got=%0d exp=3", instr_count); end
  endtask

  task automatic test_halt_req();
    int e;
    bit done;
    do_clear();
    for (int i = 0; i < 10; i++) load(8'(i), 8'h10);
    start = 1'b1; tick(); start = 1'b0;
    e = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge CLK);
      if (cpu_en) e++;
      if (e == 3) begin
        halt_req = 1'b1; @(posedge CLK); #1 halt_req = 1'b0; done = 1;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL hreq_no_exec got=%0d exp=3", e); end
    @(negedge CLK);
    total++; if (halted !== 1'b1 || instr_count !== 16'd3) begin bad++; $display("FAIL hreq_halt got=%b/%0d exp=1/3", halted, instr_count); end
    tick();
  endtask

  task automatic test_watchdog();
    bit seen;
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge CLK); if (halted) seen = 1; end
    total++; if (!seen) begin bad++; $display("FAIL wd_no_halt got=0 exp=halted"); end
    total++; if (instr_count !== 16'd5 || timeout !== 1'b1) begin bad++; $display("FAIL wd_halt got=%0d/%b exp=5/1", instr_count, timeout); end
    @(posedge CLK); #1 clear = 1'b1; tick(); clear = 1'b0;
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL wd_clear_rst got=%b exp=1", cpu_rst); end
    total++; if (timeout !== 1'b0 || instr_count !== 16'd0 || halted !== 1'b0) begin bad++; $display("FAIL wd_clear got=%b/%0d/%b exp=0/0/0", timeout, instr_count, halted); end
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL wd_rst_len got=%b exp=0", cpu_rst); end
    tick();
  endtask

  task automatic test_load_block();
    int blk;
    bit seen;
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    load_valid = 1'b1; load_addr = 8'h80; load_data = 8'hAA;
    blk = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (halted) seen = 1;
      else if (load_ready || mem_we) blk++;
      halt_req = (i == 3);
    end
    halt_req = 1'b0;
    total++; if (blk !== 0) begin bad++; $display("FAIL ld_run_blocked got=%0d exp=0", blk); end
    total++; if (!seen) begin bad++; $display("FAIL ld_no_halt got=0 exp=halted"); end
    total++; if (load_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h80) begin bad++; $display("FAIL ld_halt_accept got=%b%b/%h exp=11/80", load_ready, mem_we, mem_addr); end
    @(posedge CLK); #1 load_valid = 1'b0;
    total++; if (mem[8'h80] !== 8'hAA) begin bad++; $display("FAIL ld_mem got=%h exp=aa", mem[8'h80]); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); if (cpu_en) seen = 1; end
    total++; if (!seen) begin bad++; $display("FAIL rmid_no_exec got=0 exp=1"); end
    @(posedge CLK); @(posedge CLK); #1 reset = 1'b1;
    @(negedge CLK);
    total++; if (cpu_en !== 1'b0 || cpu_rst !== 1'b1) begin bad++; $display("FAIL rmid_en got=%b%b exp=01", cpu_en, cpu_rst); end
    @(negedge CLK);
    total++; if ({runningLED, halted, timeout, load_ready, cpu_en} !== 5'b0 || instr_count !== 16'd0 || cpu_instr !== 8'h00)
      begin bad++; $display("FAIL rmid_outs got=%b/%0d/%h exp=00000/0/00", {runningLED, halted, timeout, load_ready, cpu_en}, instr_count, cpu_instr); end
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rmid_stretch got=%b exp=1", cpu_rst); end
    @(negedge CLK);
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b exp=0", cpu_rst); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    cpu_pc = 8'h00; mem_rdata = 8'h00;
    test_reset();
    test_run_halt_instr();
    test_step();
    test_halt_req();
    test_watchdog();
    test_load_block();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
